int_ctrl: RTL and testbench

//  Parametrised interrupt controller between external interrupt lines and the CPU core.

---
 rtl/int_ctrl.sv | 124 ++++++++++++
 tb/tb_int_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// Parametrised fixed-priority, vectored interrupt controller with per-source edge/level mode.
// Optional INT_SYNC_EN: adds a 2-flop synchroniser on int_src (all input latencies +2 cycles).
module int_ctrl #(
  parameter int              N_SRC      = 2,
  parameter int              IDW        = 1,
  parameter logic [N_SRC-1:0] EDGE_MODE = {N_SRC{1'b1}},
  parameter logic [31:0]     VEC_BASE   = 32'h0000_0004,
  parameter logic [31:0]     VEC_STRIDE = 32'h0000_0004
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] int_src,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  output logic [N_SRC-1:0] mask,
  output logic [N_SRC-1:0] pending,
  output logic             int_req,
  output logic [IDW-1:0]   int_id,
  output logic [31:0]      int_vec,
  input  logic             int_ack,
  input  logic             int_ret,
  output logic             in_service
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t           state, state_nxt;
  logic [N_SRC-1:0] s, s_d, edge_pend, set_pend, clr_pend, cand;
  logic [IDW-1:0]   winner;
  logic             load, ack_take;

`ifdef INT_SYNC_EN
  logic [N_SRC-1:0] sync1, sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= int_src;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = int_src;
`endif

  assign set_pend = s & ~s_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_d       <= '0;
      edge_pend <= '0;
      mask      <= '0;
    end else begin
      s_d       <= s;
      // A new edge in the same cycle as the ack clear keeps the bit set.
      edge_pend <= (edge_pend & ~clr_pend) | set_pend;
      if (mask_we) mask <= mask_wdata;
    end
  end

  assign pending = (EDGE_MODE & edge_pend) | (~EDGE_MODE & s_d);
  assign cand    = pending & mask;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (cand[i]) winner = IDW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    ack_take  = 1'b0;
    case (state)
      IDLE: begin
        if (|cand) begin
          state_nxt = REQ;
          load      = 1'b1;
        end
      end
      REQ: begin
        // Ack has precedence over withdrawal and over a simultaneous int_ret.
        if (int_ack) begin
          state_nxt = SERVICE;
          ack_take  = 1'b1;
        end else if (!cand[int_id]) begin
          state_nxt = IDLE;
        end
      end
      SERVICE: begin
        if (int_ret) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign clr_pend = ack_take ? (N_SRC'(1) << int_id) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      int_id  <= '0;
      int_vec <= VEC_BASE;
    end else if (load) begin
      int_id  <= winner;
      int_vec <= VEC_BASE + 32'(winner) * VEC_STRIDE;
    end
  end

  assign int_req    = (state == REQ);
  assign in_service = (state == SERVICE);

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl at N_SRC=2 and default parameters.
// With INT_SYNC_EN defined only the synchroniser latency scenario is exercised.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  int_src;
  logic        mask_we;
  logic [1:0]  mask_wdata;
  logic [1:0]  mask;
  logic [1:0]  pending;
  logic        int_req;
  logic [0:0]  int_id;
  logic [31:0] int_vec;
  logic        int_ack;
  logic        int_ret;
  logic        in_service;

  int n_checks = 0;
  int n_errors = 0;

  int_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .int_src    (int_src),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .mask       (mask),
    .pending    (pending),
    .int_req    (int_req),
    .int_id     (int_id),
    .int_vec    (int_vec),
    .int_ack    (int_ack),
    .int_ret    (int_ret),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".mask"},       32'(mask),       32'h0);
    check({tag, ".pending"},    32'(pending),    32'h0);
    check({tag, ".int_req"},    32'(int_req),    32'h0);
    check({tag, ".int_id"},     32'(int_id),     32'h0);
    check({tag, ".int_vec"},    int_vec,         32'h4);
    check({tag, ".in_service"}, 32'(in_service), 32'h0);
  endtask

  task automatic write_mask(input logic [1:0] m);
    mask_we    = 1'b1;
    mask_wdata = m;
  endtask

  initial begin
    reset = 1'b1; int_src = '0; mask_we = 1'b0; mask_wdata = '0;
    int_ack = 1'b0; int_ret = 1'b0;
    step(); step();
    check_reset_values("rst");
    reset = 1'b0;

`ifdef INT_SYNC_EN
    write_mask(2'b10);
    step(); mask_we = 1'b0;
    int_src = 2'b10;
    step(); int_src = 2'b00;
    step();
    step();
    check("s6.pend_t3", 32'(pending), 32'h2);
    check("s6.req_t3",  32'(int_req), 32'h0);
    step();
    check("s6.req_t4",  32'(int_req), 32'h1);
    check("s6.id",      32'(int_id),  32'h1);
    check("s6.vec",     int_vec,      32'h8);
`else
    // 1: masked source still latches pending; unmasking raises the request.
    int_src = 2'b01;
    step(); int_src = 2'b00;
    check("t1.pend",    32'(pending), 32'h1);
    check("t1.req_lat", 32'(int_req), 32'h0);
    step();
    check("t1.req_msk", 32'(int_req), 32'h0);
    write_mask(2'b11);
    step(); mask_we = 1'b0;
    check("t1.mask",    32'(mask),    32'h3);
    check("t1.req_pre", 32'(int_req), 32'h0);
    step();
    check("t1.req",     32'(int_req), 32'h1);
    check("t1.id",      32'(int_id),  32'h0);
    check("t1.vec",     int_vec,      32'h4);
    int_ack = 1'b1;
    step(); int_ack = 1'b0;
    check("t1.svc",      32'(in_service), 32'h1);
    check("t1.req_svc",  32'(int_req),    32'h0);
    check("t1.pend_clr", 32'(pending),    32'h0);
    int_ret = 1'b1;
    step(); int_ret = 1'b0;
    check("t1.svc_end", 32'(in_service), 32'h0);

    // 2: simultaneous edges, source 0 wins, source 1 follows after return.
    int_src = 2'b11;
    step(); int_src = 2'b00;
    check("t2.pend", 32'(pending), 32'h3);
    step();
    check("t2.req0", 32'(int_req), 32'h1);
    check("t2.id0",  32'(int_id),  32'h0);
    int_ack = 1'b1;
    step(); int_ack = 1'b0;
    check("t2.pend_after_ack", 32'(pending), 32'h2);
    int_ret = 1'b1;
    step(); int_ret = 1'b0;
    check("t2.idle_req", 32'(int_req), 32'h0);
    step();
    check("t2.req1", 32'(int_req), 32'h1);
    check("t2.id1",  32'(int_id),  32'h1);
    check("t2.vec1", int_vec,      32'h8);

    // 3: masking the requested source withdraws the request without service.
    write_mask(2'b00);
    step(); mask_we = 1'b0;
    check("t3.req_hold", 32'(int_req), 32'h1);
    step();
    check("t3.req_drop", 32'(int_req),    32'h0);
    check("t3.pend",     32'(pending),    32'h2);
    check("t3.svc",      32'(in_service), 32'h0);

    // 4: new edge on src0 during its ack keeps pending[0] set.
    write_mask(2'b11); int_src = 2'b01;
    step(); mask_we = 1'b0; int_src = 2'b00;
    check("t4.pend", 32'(pending), 32'h3);
    step();
    check("t4.req", 32'(int_req), 32'h1);
    check("t4.id",  32'(int_id),  32'h0);
    int_ack = 1'b1; int_src = 2'b01;
    step(); int_ack = 1'b0; int_src = 2'b00;
    check("t4.pend_keep", 32'(pending),    32'h3);
    check("t4.svc",       32'(in_service), 32'h1);
    int_ret = 1'b1;
    step(); int_ret = 1'b0;
    check("t4.idle", 32'(int_req), 32'h0);
    step();
    check("t4.rereq", 32'(int_req), 32'h1);
    check("t4.reid",  32'(int_id),  32'h0);
    check("t4.revec", int_vec,      32'h4);

    // 5: reset during service with both sources pending.
    int_ack = 1'b1; int_src = 2'b01;
    step(); int_ack = 1'b0; int_src = 2'b00;
    check("t5.svc",  32'(in_service), 32'h1);
    check("t5.pend", 32'(pending),    32'h3);
    reset = 1'b1;
    step(); reset = 1'b0;
    check_reset_values("t5");
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
